// File: rtl/pipe_ctrl.sv
// Pipelined control unit for the five-stage MIPS-subset datapath: D-stage decode,
// E/M/W control pipeline registers, load-use stall, branch/jump flush and event counters.
module pipe_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             ZeroM,
  output logic             RegDstE,
  output logic             ALUSrcB,
  output logic [2:0]       ALUControlE,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic             JumpC,
  output logic             RegWriteW,
  output logic             MemToReg,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_J     = 6'b000010
  } opcode_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctl;
  } ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic branch;
  } ctrl_m_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } ctrl_w_t;

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_e;
  ctrl_m_t    ctrl_m;
  ctrl_w_t    ctrl_w;
  logic [4:0] rt_e;
  logic       jump_d;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       lwstall;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b000;
    case (Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Unknown opcodes and unknown R-type functs decode to the all-zero NOP word.
  always_comb begin
    ctrl_d = '0;
    jump_d = 1'b0;
    case (Opcode)
      OP_RTYPE: if (funct_ok) begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.alu_ctl   = funct_alu;
      end
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.alu_ctl    = 3'b010;
      end
      OP_SW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctl   = 3'b010;
      end
      OP_BEQ: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_ctl = 3'b110;
      end
      OP_ADDI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctl   = 3'b010;
      end
      OP_J: begin
        ctrl_d.alu_ctl = 3'b010;
        jump_d         = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // A taken branch in M outranks both the load-use stall and a jump in D.
  assign PCSrc   = ctrl_m.branch & ZeroM;
  assign lwstall = ctrl_e.mem_to_reg & ctrl_e.reg_write & ((rt_e == RsD) | (rt_e == RtD));
  assign JumpC   = jump_d & ~PCSrc;
  assign StallF  = lwstall & ~PCSrc;
  assign StallD  = lwstall & ~PCSrc;
  assign FlushD  = PCSrc | JumpC;
  assign FlushE  = PCSrc | lwstall;

  assign RegDstE     = ctrl_e.reg_dst;
  assign ALUSrcB     = ctrl_e.alu_src;
  assign ALUControlE = ctrl_e.alu_ctl;
  assign MemWrite    = ctrl_m.mem_write;
  assign RegWriteW   = ctrl_w.reg_write;
  assign MemToReg    = ctrl_w.mem_to_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_e   <= '0;
      rt_e     <= '0;
      ctrl_m   <= '0;
      ctrl_w   <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      ctrl_e <= FlushE ? ctrl_t'('0) : ctrl_d;
      rt_e   <= RtD;
      ctrl_m <= PCSrc ? ctrl_m_t'('0)
                      : {ctrl_e.reg_write, ctrl_e.mem_to_reg, ctrl_e.mem_write, ctrl_e.branch};
      ctrl_w <= {ctrl_m.reg_write, ctrl_m.mem_to_reg};
      if (StallF && StallCnt != '1) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && FlushCnt != '1) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: decode, stage alignment, load-use stall, branch/jump
// flush, priority interactions and counter saturation (second instance with narrow counters).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic        ZeroM;

  logic        RegDstE, ALUSrcB, MemWrite, PCSrc, JumpC, RegWriteW, MemToReg;
  logic        StallF, StallD, FlushD, FlushE;
  logic [2:0]  ALUControlE;
  logic [15:0] StallCnt, FlushCnt;

  logic        s_RegDstE, s_ALUSrcB, s_MemWrite, s_PCSrc, s_JumpC, s_RegWriteW, s_MemToReg;
  logic        s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [2:0]  s_ALUControlE;
  logic [3:0]  s_StallCnt, s_FlushCnt;

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .RsD(RsD), .RtD(RtD),
    .ZeroM(ZeroM), .RegDstE(RegDstE), .ALUSrcB(ALUSrcB), .ALUControlE(ALUControlE),
    .MemWrite(MemWrite), .PCSrc(PCSrc), .JumpC(JumpC), .RegWriteW(RegWriteW),
    .MemToReg(MemToReg), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  pipe_ctrl #(.CNT_W(4)) sat (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .RsD(RsD), .RtD(RtD),
    .ZeroM(ZeroM), .RegDstE(s_RegDstE), .ALUSrcB(s_ALUSrcB), .ALUControlE(s_ALUControlE),
    .MemWrite(s_MemWrite), .PCSrc(s_PCSrc), .JumpC(s_JumpC), .RegWriteW(s_RegWriteW),
    .MemToReg(s_MemToReg), .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD),
    .FlushE(s_FlushE), .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  localparam logic [5:0] OPR = 6'b000000, OLW = 6'b100011, OSW = 6'b101011;
  localparam logic [5:0] OBEQ = 6'b000100, OADDI = 6'b001000, OJ = 6'b000010;
  localparam logic [5:0] FADD = 6'b100000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    Opcode = op; Funct = fn; RsD = rs; RtD = rt;
  endtask

  logic [5:0] t_op  [8] = '{OPR, OPR, OPR, OPR, OPR, OPR, OADDI, 6'b111111};
  logic [5:0] t_fn  [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b000001, 6'b000000, 6'b000000};
  logic [2:0] t_alu [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b000, 3'b010, 3'b000};
  logic       t_rd  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       t_src [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  initial begin
    reset = 1'b0; ZeroM = 1'b0;
    drive(OLW, 6'd0, 5'd0, 5'd0);
    tick(); tick();
    chk("rst_regdst", RegDstE === 1'b0);
    chk("rst_alusrc", ALUSrcB === 1'b0);
    chk("rst_aluctl", ALUControlE === 3'b000);
    chk("rst_memwrite", MemWrite === 1'b0);
    chk("rst_pcsrc", PCSrc === 1'b0);
    chk("rst_regwritew", RegWriteW === 1'b0);
    chk("rst_memtoreg", MemToReg === 1'b0);
    chk("rst_stallf", StallF === 1'b0);
    chk("rst_flushe", FlushE === 1'b0);
    chk("rst_stallcnt", StallCnt === 16'd0);
    chk("rst_flushcnt", FlushCnt === 16'd0);

    reset = 1'b1;
    drive(OPR, FADD, 5'd1, 5'd2);
    tick();
    chk("add_aluctl_e", ALUControlE === 3'b010);
    chk("add_regdst_e", RegDstE === 1'b1);
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick();
    chk("add_regwritew_early", RegWriteW === 1'b0);
    tick();
    chk("add_regwritew", RegWriteW === 1'b1);
    chk("add_memtoreg", MemToReg === 1'b0);
    tick();
    chk("nop_regwritew", RegWriteW === 1'b0);

    for (int i = 0; i < 8; i++) begin
      drive(t_op[i], t_fn[i], 5'd1, 5'd2);
      tick();
      chk("dec_aluctl", ALUControlE === t_alu[i]);
      chk("dec_regdst", RegDstE === t_rd[i]);
      chk("dec_alusrc", ALUSrcB === t_src[i]);
    end
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick(); tick(); tick();

    drive(OSW, 6'd0, 5'd1, 5'd2);
    tick();
    chk("sw_alusrc", ALUSrcB === 1'b1);
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick();
    chk("sw_memwrite", MemWrite === 1'b1);
    tick();
    chk("sw_memwrite_off", MemWrite === 1'b0);
    chk("sw_regwritew", RegWriteW === 1'b0);

    drive(OLW, 6'd0, 5'd0, 5'd5);
    #1;
    chk("lw_nostall", StallF === 1'b0);
    tick();
    chk("lw_alusrc_e", ALUSrcB === 1'b1);
    drive(OPR, FADD, 5'd5, 5'd6);
    #1;
    chk("lu_stallf", StallF === 1'b1);
    chk("lu_stalld", StallD === 1'b1);
    chk("lu_flushe", FlushE === 1'b1);
    chk("lu_flushd", FlushD === 1'b0);
    tick();
    chk("lu_bubble_aluctl", ALUControlE === 3'b000);
    chk("lu_bubble_regdst", RegDstE === 1'b0);
    chk("lu_stallcnt", StallCnt === 16'd1);
    chk("lu_stall_clear", StallF === 1'b0);
    tick();
    chk("lu_add_late_regdst", RegDstE === 1'b1);
    chk("lu_add_late_aluctl", ALUControlE === 3'b010);
    chk("lw_regwritew", RegWriteW === 1'b1);
    chk("lw_memtoreg", MemToReg === 1'b1);
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick(); tick(); tick();

    drive(OBEQ, 6'd0, 5'd1, 5'd2);
    tick();
    chk("beq_aluctl_e", ALUControlE === 3'b110);
    drive(OPR, FADD, 5'd1, 5'd2);
    tick();
    drive(OSW, 6'd0, 5'd3, 5'd4);
    ZeroM = 1'b1;
    #1;
    chk("bt_pcsrc", PCSrc === 1'b1);
    chk("bt_flushd", FlushD === 1'b1);
    chk("bt_flushe", FlushE === 1'b1);
    chk("bt_stallf", StallF === 1'b0);
    tick();
    chk("bt_pcsrc_after", PCSrc === 1'b0);
    chk("bt_e_killed", ALUSrcB === 1'b0);
    chk("bt_flushcnt", FlushCnt === 16'd1);
    ZeroM = 1'b0;
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick();
    chk("bt_w_killed", RegWriteW === 1'b0);
    chk("bt_m_killed", MemWrite === 1'b0);
    tick(); tick();

    drive(OBEQ, 6'd0, 5'd1, 5'd2);
    tick();
    drive(OPR, FADD, 5'd1, 5'd2);
    tick();
    drive(OPR, 6'd0, 5'd0, 5'd0);
    #1;
    chk("bn_pcsrc", PCSrc === 1'b0);
    chk("bn_flushd", FlushD === 1'b0);
    chk("bn_flushe", FlushE === 1'b0);
    tick(); tick();
    chk("bn_add_regwritew", RegWriteW === 1'b1);
    chk("bn_flushcnt", FlushCnt === 16'd1);
    tick(); tick();

    drive(OJ, 6'd0, 5'd0, 5'd0);
    #1;
    chk("j_jumpc", JumpC === 1'b1);
    chk("j_flushd", FlushD === 1'b1);
    chk("j_flushe", FlushE === 1'b0);
    tick();
    chk("j_flushcnt", FlushCnt === 16'd2);
    chk("j_regdst_e", RegDstE === 1'b0);
    drive(OPR, 6'd0, 5'd0, 5'd0);
    #1;
    chk("j_jumpc_off", JumpC === 1'b0);
    chk("j_flushd_off", FlushD === 1'b0);
    tick(); tick();
    chk("j_regwritew", RegWriteW === 1'b0);
    tick();

    drive(OBEQ, 6'd0, 5'd1, 5'd2);
    tick();
    drive(OLW, 6'd0, 5'd0, 5'd5);
    tick();
    drive(OPR, FADD, 5'd5, 5'd6);
    ZeroM = 1'b1;
    #1;
    chk("bl_stallf", StallF === 1'b0);
    chk("bl_stalld", StallD === 1'b0);
    chk("bl_flushd", FlushD === 1'b1);
    chk("bl_flushe", FlushE === 1'b1);
    tick();
    chk("bl_stallcnt", StallCnt === 16'd1);
    chk("bl_flushcnt", FlushCnt === 16'd3);
    ZeroM = 1'b0;
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick();
    chk("bl_lw_killed", RegWriteW === 1'b0);
    tick();

    drive(OBEQ, 6'd0, 5'd1, 5'd2);
    tick();
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick();
    drive(OJ, 6'd0, 5'd0, 5'd0);
    ZeroM = 1'b1;
    #1;
    chk("bj_jumpc", JumpC === 1'b0);
    chk("bj_pcsrc", PCSrc === 1'b1);
    chk("bj_flushd", FlushD === 1'b1);
    tick();
    chk("bj_flushcnt", FlushCnt === 16'd4);
    ZeroM = 1'b0;
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick(); tick();

    drive(OLW, 6'd0, 5'd5, 5'd5);
    repeat (40) tick();
    chk("sat_wide_stallcnt", StallCnt === 16'd21);
    chk("sat_narrow_stallcnt", s_StallCnt === 4'd15);
    chk("sat_narrow_flushcnt", s_FlushCnt === 4'd4);
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick(); tick();

    drive(OPR, FADD, 5'd1, 5'd2);
    tick();
    chk("mr_add_e", RegDstE === 1'b1);
    reset = 1'b0;
    drive(OPR, 6'd0, 5'd0, 5'd0);
    tick();
    chk("mr_regdst", RegDstE === 1'b0);
    chk("mr_aluctl", ALUControlE === 3'b000);
    chk("mr_stallcnt", StallCnt === 16'd0);
    chk("mr_flushcnt", FlushCnt === 16'd0);
    reset = 1'b1;
    tick();
    chk("mr_regwritew", RegWriteW === 1'b0);
    tick();

    done = 1'b1;
    if (errors != 0) $error("FAIL summary: %0d of %0d checks failed", errors, checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
